// File: rtl/hwag_pkg.sv
// hwag_pkg: shared state type and constants for the hwag tooth tracker
package hwag_pkg;
    typedef enum logic [1:0] {IDLE, FIRST, SEARCH, SYNC} tooth_state_t;
    localparam int GAP_SHIFT = 1;
    function automatic int last_tooth(input int total, input int missing);
        return total - missing - 1;
    endfunction
endpackage

// File: rtl/hwag_period_timer.sv
// hwag_period_timer: saturating edge-to-edge cycle counter
//   clk, rst (sync, active-low); i_clear holds count at 0; i_start reloads 1;
//   o_count current count; o_sat high while count is all-ones
module hwag_period_timer #(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_start,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_sat
);
    logic [CNT_WIDTH-1:0] r_count;
    assign o_count = r_count;
    assign o_sat   = &r_count;
    always_ff @(posedge clk)
        if (!rst || i_clear) r_count <= '0;
        else if (i_start)    r_count <= CNT_WIDTH'(1);
        else if (!o_sat)     r_count <= r_count + 1'b1;
endmodule

// File: rtl/hwag_tooth_tracker.sv
// hwag_tooth_tracker: tooth period measurement and missing-tooth sync
//   clk, rst (sync, active-low), ena, cap_edge in;
//   tooth_num, sync, period, period_valid, gap_pulse, err_pulse, stall out (all registered)
module hwag_tooth_tracker
    import hwag_pkg::*;
#(
    parameter int CNT_WIDTH     = 24,
    parameter int TOOTH_TOTAL   = 60,
    parameter int TOOTH_MISSING = 2,
    parameter int TOOTH_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   cap_edge,
    output logic [TOOTH_WIDTH-1:0] tooth_num,
    output logic                   sync,
    output logic [CNT_WIDTH-1:0]   period,
    output logic                   period_valid,
    output logic                   gap_pulse,
    output logic                   err_pulse,
    output logic                   stall
);
    localparam int                     L_INT = last_tooth(TOOTH_TOTAL, TOOTH_MISSING);
    localparam logic [TOOTH_WIDTH-1:0] L     = L_INT[TOOTH_WIDTH-1:0];

    tooth_state_t           r_state, w_state;
    logic [CNT_WIDTH-1:0]   r_prev, w_prev, r_period, w_period, w_cur;
    logic [TOOTH_WIDTH-1:0] r_tooth, w_tooth;
    logic                   r_sync, w_sync, r_pv, w_pv, r_gap_p, w_gap_p;
    logic                   r_err_p, w_err_p, r_stall_p, w_stall_p;
    logic                   w_sat, w_gap, w_clear;

    // Timer is held at zero while idle unless an edge is starting a measurement
    assign w_clear = !ena || (r_state == IDLE && !cap_edge);
    // Extra bit keeps prev<<1 from wrapping
    assign w_gap   = {1'b0, w_cur} >= ({1'b0, r_prev} << GAP_SHIFT);

    hwag_period_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_start (cap_edge),
        .o_count (w_cur),
        .o_sat   (w_sat)
    );

    always_ff @(posedge clk)
        if (!rst) begin
            r_state   <= IDLE;
            r_prev    <= '0;
            r_period  <= '0;
            r_tooth   <= '0;
            r_sync    <= 1'b0;
            r_pv      <= 1'b0;
            r_gap_p   <= 1'b0;
            r_err_p   <= 1'b0;
            r_stall_p <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_prev    <= w_prev;
            r_period  <= w_period;
            r_tooth   <= w_tooth;
            r_sync    <= w_sync;
            r_pv      <= w_pv;
            r_gap_p   <= w_gap_p;
            r_err_p   <= w_err_p;
            r_stall_p <= w_stall_p;
        end

    always_comb begin
        w_state   = r_state;
        w_prev    = r_prev;
        w_period  = r_period;
        w_tooth   = r_tooth;
        w_sync    = r_sync;
        w_pv      = 1'b0;
        w_gap_p   = 1'b0;
        w_err_p   = 1'b0;
        w_stall_p = 1'b0;
        if (!ena) begin
            w_state = IDLE;
            w_sync  = 1'b0;
            w_tooth = '0;
        end else if (r_state == IDLE) begin
            w_state = cap_edge ? FIRST : IDLE;
        end else if (w_sat) begin
            // A saturated count is not a valid period: restart on an edge, else stall
            w_state   = cap_edge ? FIRST : IDLE;
            w_stall_p = !cap_edge;
            w_sync    = 1'b0;
            w_tooth   = '0;
        end else if (cap_edge) begin
            w_prev   = w_cur;
            w_period = w_cur;
            w_pv     = 1'b1;
            if (r_state == FIRST) begin
                w_state = SEARCH;
            end else if (r_state == SEARCH) begin
                w_state = w_gap ? SYNC : SEARCH;
                w_sync  = w_gap;
                w_gap_p = w_gap;
                w_tooth = '0;
            end else if (r_tooth == L && w_gap) begin
                w_tooth = '0;
                w_gap_p = 1'b1;
            end else if (r_tooth != L && !w_gap) begin
                w_tooth = r_tooth + 1'b1;
            end else begin
                w_state = SEARCH;
                w_sync  = 1'b0;
                w_tooth = '0;
                w_err_p = 1'b1;
            end
        end
    end

    assign tooth_num    = r_tooth;
    assign sync         = r_sync;
    assign period       = r_period;
    assign period_valid = r_pv;
    assign gap_pulse    = r_gap_p;
    assign err_pulse    = r_err_p;
    assign stall        = r_stall_p;
endmodule
